cbus_arbiter: RTL and testbench

- Shares one CBus slave port (the crossbar input) between NREQ CBus masters, e.g. the instruction-fetch and data-access paths of the CPU.
- Round-robin arbitration at transaction granularity. A grant is held from the first beat until the final ready&last handshake, so bursts are never interleaved.
- Sits between the core's memory units and the CBus crossbar. Purely sequential control; no buffering of data.

---
 rtl/cbus_arbiter.sv | 121 ++++++++++++
 tb/tb_cbus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter: shares one crossbar port between NREQ masters,
// holding each grant for a whole transaction.
module cbus_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*AW-1:0] req_wdata,
    input  logic [NREQ*3-1:0] req_size,
    input  logic [NREQ*8-1:0] req_wstrobe,
    input  logic [NREQ*2-1:0] req_burst,
    input  logic [NREQ*8-1:0] req_len,
    output logic [NREQ-1:0]   resp_ready,
    output logic [NREQ-1:0]   resp_last,
    output logic [AW-1:0]     resp_rdata,
    output logic              valid,
    output logic [AW-1:0]     addr,
    output logic [AW-1:0]     wdata,
    output logic [2:0]        size,
    output logic [7:0]        wstrobe,
    output logic [1:0]        burst,
    output logic [7:0]        len,
    input  logic              ready,
    input  logic              last,
    input  logic [AW-1:0]     rdata
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gsel_q, gsel_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] win;
    logic [GW-1:0] gnext;
    logic          busy;
    int            idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gsel_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gsel_q  <= gsel_d;
            rr_q    <= rr_d;
        end
    end

    // Scan downward so the lowest offset from rr is assigned last and wins.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win = GW'(idx);
            end
        end
    end

    assign gnext = (gsel_q == GW'(NREQ - 1)) ? '0 : gsel_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gsel_d  = gsel_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gsel_d  = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if ((ready && last) || !req_valid[gsel_q]) begin
                    state_d = IDLE;
                    rr_d    = gnext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == BUSY) && !reset;

    always_comb begin
        valid      = 1'b0;
        addr       = '0;
        wdata      = '0;
        size       = '0;
        wstrobe    = '0;
        burst      = '0;
        len        = '0;
        resp_ready = '0;
        resp_last  = '0;
        if (busy) begin
            valid   = req_valid[gsel_q];
            addr    = req_addr[int'(gsel_q)*AW +: AW];
            wdata   = req_wdata[int'(gsel_q)*AW +: AW];
            size    = req_size[int'(gsel_q)*3 +: 3];
            wstrobe = req_wstrobe[int'(gsel_q)*8 +: 8];
            burst   = req_burst[int'(gsel_q)*2 +: 2];
            len     = req_len[int'(gsel_q)*8 +: 8];
            for (int i = 0; i < NREQ; i++) begin
                if (gsel_q == GW'(i)) begin
                    resp_ready[i] = ready;
                    resp_last[i]  = last;
                end
            end
        end
    end

    assign resp_rdata = reset ? '0 : rdata;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter (NREQ=2, AW=64).
module tb_cbus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 64;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*AW-1:0] req_wdata;
    logic [NREQ*3-1:0] req_size;
    logic [NREQ*8-1:0] req_wstrobe;
    logic [NREQ*2-1:0] req_burst;
    logic [NREQ*8-1:0] req_len;
    logic [NREQ-1:0]   resp_ready;
    logic [NREQ-1:0]   resp_last;
    logic [AW-1:0]     resp_rdata;
    logic              valid;
    logic [AW-1:0]     addr;
    logic [AW-1:0]     wdata;
    logic [2:0]        size;
    logic [7:0]        wstrobe;
    logic [1:0]        burst;
    logic [7:0]        len;
    logic              ready;
    logic              last;
    logic [AW-1:0]     rdata;

    int checks = 0;
    int errors = 0;

    cbus_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_wstrobe(req_wstrobe), .req_burst(req_burst),
        .req_len(req_len), .resp_ready(resp_ready),
        .resp_last(resp_last), .resp_rdata(resp_rdata),
        .valid(valid), .addr(addr), .wdata(wdata),
        .size(size), .wstrobe(wstrobe), .burst(burst),
        .len(len), .ready(ready), .last(last), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A1 = 64'h0000_0000_9000_0040;

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = {A1, A0};
        req_wdata   = '0;
        req_size    = {3'd3, 3'd2};
        req_wstrobe = '0;
        req_burst   = {2'd1, 2'd0};
        req_len     = '0;
        ready       = 1'b0;
        last        = 1'b0;
        rdata       = 64'h55;
        settle();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("idle_rdata", resp_rdata, 64'h55);

        // Single request, single beat
        req_valid = 2'b01;
        settle();
        chk("t1_idle_valid", 64'(valid), 64'd0);
        tick();
        chk("t1_valid", 64'(valid), 64'd1);
        chk("t1_addr", addr, A0);
        chk("t1_size", 64'(size), 64'd2);
        ready = 1'b1;
        last  = 1'b1;
        settle();
        chk("t1_rready", 64'(resp_ready), 64'd1);
        chk("t1_rlast", 64'(resp_last), 64'd1);
        tick();
        req_valid = 2'b00;
        ready = 1'b0;
        last  = 1'b0;
        settle();
        chk("t1_after_valid", 64'(valid), 64'd0);

        // Both masters requesting: alternation with a dead cycle
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t2_valid", 64'(valid), 64'd1);
            chk("t2_addr", addr, (n % 2 == 0) ? A0 : A1);
            chk("t2_nordy", 64'(resp_ready), 64'd0);
            tick();
            ready = 1'b1;
            last  = 1'b1;
            settle();
            chk("t2_rready", 64'(resp_ready),
                (n % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            ready = 1'b0;
            last  = 1'b0;
            settle();
            chk("t2_gap", 64'(valid), 64'd0);
        end
        req_valid = 2'b00;
        tick();

        // Master 1 burst, master 0 arrives at beat 2
        req_len = {8'd3, 8'd0};
        req_valid = 2'b10;
        tick();
        chk("t3_valid", 64'(valid), 64'd1);
        chk("t3_len", 64'(len), 64'd3);
        chk("t3_burst", 64'(burst), 64'd1);
        for (int b = 0; b < 4; b++) begin
            ready = 1'b1;
            last  = (b == 3);
            rdata = 64'h11 * (b + 1);
            if (b == 1) req_valid = 2'b11;
            settle();
            chk("t3_rready", 64'(resp_ready), 64'd2);
            chk("t3_rlast", 64'(resp_last), (b == 3) ? 64'd2 : 64'd0);
            chk("t3_rdata", resp_rdata, 64'h11 * (b + 1));
            chk("t3_addr", addr, A1);
            tick();
        end
        ready = 1'b0;
        last  = 1'b0;
        req_valid = 2'b01;
        settle();
        chk("t3_gap", 64'(valid), 64'd0);
        tick();
        chk("t3_m0_valid", 64'(valid), 64'd1);
        chk("t3_m0_addr", addr, A0);
        ready = 1'b1;
        last  = 1'b1;
        tick();
        ready = 1'b0;
        last  = 1'b0;
        req_valid = 2'b00;
        tick();

        // Master 0 write passthrough; rr should then favour master 1
        req_wdata[63:0]  = 64'hDEAD_BEEF;
        req_wstrobe[7:0] = 8'hFF;
        req_valid = 2'b01;
        tick();
        chk("t4_wdata", wdata, 64'hDEAD_BEEF);
        chk("t4_wstrobe", 64'(wstrobe), 64'hFF);
        ready = 1'b1;
        last  = 1'b1;
        tick();
        ready = 1'b0;
        last  = 1'b0;
        req_valid = 2'b11;
        tick();
        chk("t4_rr_grant", addr, A1);
        chk("t4_rr_wstrobe", 64'(wstrobe), 64'h00);

        // Reset in the middle of master 1's burst
        ready = 1'b1;
        settle();
        chk("t5_pre_rready", 64'(resp_ready), 64'd2);
        reset = 1'b1;
        settle();
        chk("t5_valid", 64'(valid), 64'd0);
        chk("t5_rready", 64'(resp_ready), 64'd0);
        tick();
        reset = 1'b0;
        ready = 1'b0;
        settle();
        chk("t5_idle", 64'(valid), 64'd0);
        tick();
        chk("t5_regrant", addr, A0);
        chk("t5_regrant_v", 64'(valid), 64'd1);

        // Granted master 0 drops valid; master 1 picks up
        req_valid = 2'b10;
        settle();
        chk("t6_drop", 64'(valid), 64'd0);
        tick();
        chk("t6_idle", 64'(valid), 64'd0);
        tick();
        chk("t6_valid", 64'(valid), 64'd1);
        chk("t6_addr", addr, A1);
        ready = 1'b1;
        last  = 1'b1;
        settle();
        chk("t6_rready", 64'(resp_ready), 64'd2);
        tick();
        ready = 1'b0;
        last  = 1'b0;
        req_valid = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
